// File: rtl/systolic_pkg.sv
// Shared types and the per-PE semiring fold for the systolic row.
// The fold works on fixed wide operands; callers zero-extend in and truncate out.
package systolic_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_WRAP = 2'd0;
  localparam mode_t MODE_SAT  = 2'd1;
  localparam mode_t MODE_TROP = 2'd2;
  localparam mode_t MODE_BOOL = 2'd3;

  // Wide enough for AW <= 63 and DW <= 32.
  localparam int FOLD_W = 64;
  localparam int OPND_W = 32;

  typedef struct packed {
    logic [FOLD_W-1:0] acc;
    logic              ovf;
  } fold_t;

  function automatic fold_t pe_fold(input mode_t             mode,
                                    input logic [FOLD_W-1:0] acc,
                                    input logic [OPND_W-1:0] a,
                                    input logic [OPND_W-1:0] b,
                                    input int                aw);
    fold_t             r;
    logic [FOLD_W-1:0] mask;
    logic [FOLD_W-1:0] p;
    logic [FOLD_W-1:0] pc;
    logic [FOLD_W-1:0] s;
    logic [FOLD_W:0]   sum;
    mask  = (FOLD_W'(1) << aw) - FOLD_W'(1);
    p     = FOLD_W'(a) * FOLD_W'(b);
    pc    = (p > mask) ? mask : p;
    s     = FOLD_W'(a) + FOLD_W'(b);
    r.acc = acc;
    r.ovf = 1'b0;
    sum   = '0;
    case (mode)
      MODE_WRAP: begin
        sum   = {1'b0, acc} + {1'b0, p};
        r.acc = sum[FOLD_W-1:0] & mask;
        r.ovf = (sum > {1'b0, mask});
      end
      MODE_SAT: begin
        sum   = {1'b0, acc} + {1'b0, pc};
        r.acc = (sum > {1'b0, mask}) ? mask : sum[FOLD_W-1:0];
        r.ovf = (p > mask) || (sum > {1'b0, mask});
      end
      MODE_TROP: r.acc = (s > acc) ? s : acc;
      MODE_BOOL: r.acc = acc | FOLD_W'(a & b);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/systolic_row_if.sv
// Stream-in / result-out handshake bundle for systolic_row.
// With SYSTOLIC_ROW_OVF_FLAG_EN defined, carries the per-lane sticky ovf flags.
interface systolic_row_if #(
  parameter int N  = 8,
  parameter int DW = 8,
  parameter int AW = 16
);
  import systolic_pkg::*;

  mode_t           mode;
  logic            in_valid;
  logic            in_ready;
  logic            in_last;
  logic [DW-1:0]   a_in;
  logic [N*DW-1:0] b_in;
  logic            out_valid;
  logic            out_ready;
  logic [N*AW-1:0] out_data;
  logic            busy;
`ifdef SYSTOLIC_ROW_OVF_FLAG_EN
  logic [N-1:0]    ovf;

  modport master (output mode, in_valid, in_last, a_in, b_in, out_ready,
                  input  in_ready, out_valid, out_data, busy, ovf);
  modport slave  (input  mode, in_valid, in_last, a_in, b_in, out_ready,
                  output in_ready, out_valid, out_data, busy, ovf);
`else
  modport master (output mode, in_valid, in_last, a_in, b_in, out_ready,
                  input  in_ready, out_valid, out_data, busy);
  modport slave  (input  mode, in_valid, in_last, a_in, b_in, out_ready,
                  output in_ready, out_valid, out_data, busy);
`endif

endinterface

// File: rtl/systolic_pe.sv
// One processing element: forwards a/valid by one stage and folds a*b into its accumulator.
// SYSTOLIC_ROW_OVF_FLAG_EN adds a sticky per-PE overflow flag.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  mode_t         mode,
  input  logic          v_in,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] b_in,
  output logic          v_out,
  output logic [DW-1:0] a_out,
  output logic [AW-1:0] acc
`ifdef SYSTOLIC_ROW_OVF_FLAG_EN
  ,
  output logic          ovf
`endif
);

  fold_t nxt;
  logic  unused_fold;

  assign nxt = pe_fold(mode, FOLD_W'(acc), OPND_W'(a_in), OPND_W'(b_in), AW);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_out <= 1'b0;
      a_out <= '0;
      acc   <= '0;
    end else begin
      v_out <= v_in;
      a_out <= a_in;
      if (clr)       acc <= '0;
      else if (v_in) acc <= nxt.acc[AW-1:0];
    end
  end

`ifdef SYSTOLIC_ROW_OVF_FLAG_EN
  always_ff @(posedge clk) begin
    if (reset || clr)        ovf <= 1'b0;
    else if (v_in && nxt.ovf) ovf <= 1'b1;
  end

  assign unused_fold = ^nxt.acc[FOLD_W-1:AW];
`else
  assign unused_fold = ^{nxt.acc[FOLD_W-1:AW], nxt.ovf};
`endif

endmodule

// File: rtl/systolic_row.sv
// 1-D systolic row: a streams PE to PE, lane i's b is skewed i cycles to meet it.
// Optional SYSTOLIC_ROW_OVF_FLAG_EN exposes per-lane sticky overflow flags.
module systolic_row
  import systolic_pkg::*;
#(
  parameter int N  = 8,
  parameter int DW = 8,
  parameter int AW = 16
) (
  input  logic clk,
  input  logic reset,
  systolic_row_if.slave bus
);

  logic          accept;
  logic          accept_last;
  logic          fold_last;
  logic          res_accept;
  logic          active;
  logic          last_seen;
  logic          out_valid_q;
  mode_t         mode_q;
  mode_t         pe0_mode;
  logic          v_link [N+1];
  logic [DW-1:0] a_link [N+1];
  logic [AW-1:0] acc_arr [N];
  logic          unused_tail;
`ifdef SYSTOLIC_ROW_OVF_FLAG_EN
  logic          ovf_arr [N];
`endif

  assign bus.in_ready  = !out_valid_q && !last_seen;
  assign accept        = bus.in_valid && bus.in_ready;
  assign accept_last   = accept && bus.in_last;
  assign res_accept    = out_valid_q && bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = active;

  // PE0 folds the first beat in the same cycle the mode is latched.
  assign pe0_mode  = active ? mode_q : bus.mode;
  assign v_link[0] = accept;
  assign a_link[0] = bus.a_in;
  assign unused_tail = v_link[N] ^ (^a_link[N]);

  // The last token reaches PE N-1 in the cycle it folds the final beat.
  if (N == 1) begin : g_last_direct
    assign fold_last = accept_last;
  end else begin : g_last_pipe
    logic [N-2:0] last_q;
    always_ff @(posedge clk) begin
      if (reset) begin
        last_q <= '0;
      end else begin
        last_q[0] <= accept_last;
        for (int k = 1; k < N - 1; k++) last_q[k] <= last_q[k-1];
      end
    end
    assign fold_last = last_q[N-2];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q      <= MODE_WRAP;
      active      <= 1'b0;
      last_seen   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (accept && !active) mode_q <= bus.mode;
      if (res_accept) begin
        active      <= 1'b0;
        last_seen   <= 1'b0;
        out_valid_q <= 1'b0;
      end else begin
        if (accept)      active      <= 1'b1;
        if (accept_last) last_seen   <= 1'b1;
        if (fold_last)   out_valid_q <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DW-1:0] b_lane;

    if (i == 0) begin : g_noskew
      assign b_lane = bus.b_in[0 +: DW];
    end else begin : g_skew
      logic [DW-1:0] sk [i];
      // NOTE: skew stages are reset too, so a reset mid-vector cannot leak stale operands.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int k = 0; k < i; k++) sk[k] <= '0;
        end else begin
          sk[0] <= bus.b_in[i*DW +: DW];
          for (int k = 1; k < i; k++) sk[k] <= sk[k-1];
        end
      end
      assign b_lane = sk[i-1];
    end

    systolic_pe #(.DW(DW), .AW(AW)) u_pe (
      .clk   (clk),
      .reset (reset),
      .clr   (res_accept),
      .mode  ((i == 0) ? pe0_mode : mode_q),
      .v_in  (v_link[i]),
      .a_in  (a_link[i]),
      .b_in  (b_lane),
      .v_out (v_link[i+1]),
      .a_out (a_link[i+1]),
      .acc   (acc_arr[i])
`ifdef SYSTOLIC_ROW_OVF_FLAG_EN
      ,
      .ovf   (ovf_arr[i])
`endif
    );
  end

  // NOTE: default every always_comb output first so no latch is inferred.
  always_comb begin
    bus.out_data = '0;
    for (int i = 0; i < N; i++) bus.out_data[i*AW +: AW] = acc_arr[i];
  end

`ifdef SYSTOLIC_ROW_OVF_FLAG_EN
  always_comb begin
    bus.ovf = '0;
    for (int i = 0; i < N; i++) bus.ovf[i] = ovf_arr[i];
  end
`endif

endmodule
